// File: rtl/barrel_shifter_pipe_pkg.sv
// rtl/barrel_shifter_pipe_pkg.sv - shared op encodings and rank-split helpers for barrel_shifter_pipe
// Contents:
//   shift_op_e  : 2-bit operation code (SHL, SRL, SRA, ROTL)
//   rank_first  : index of the first log stage owned by a register rank
//   rank_of     : register rank that owns a given log stage
package barrel_shifter_pipe_pkg;

  typedef enum logic [1:0] {
    OP_SHL  = 2'b00,
    OP_SRL  = 2'b01,
    OP_SRA  = 2'b10,
    OP_ROTL = 2'b11
  } shift_op_e;

  // Stages are dealt out as evenly as possible; the first (shw % ranks)
  // ranks each take one extra stage. rank_first(ranks) == shw.
  function automatic int rank_first(input int r, input int shw, input int ranks);
    int base;
    int rem;
    base = shw / ranks;
    rem  = shw % ranks;
    return r * base + ((r < rem) ? r : rem);
  endfunction

  function automatic int rank_of(input int k, input int shw, input int ranks);
    int res;
    res = 0;
    for (int r = 0; r < ranks; r++) begin
      if (k >= rank_first(r, shw, ranks)) res = r;
    end
    return res;
  endfunction

endpackage

// File: rtl/barrel_shifter_pipe_shift_stage.sv
// rtl/barrel_shifter_pipe_shift_stage.sv - one combinational log stage of the barrel shifter
// Ports:
//   d    in  WIDTH  stage input
//   en   in  1      apply the DIST shift (amount bit for this stage)
//   op   in  2      shift_op_e operation
//   fill in  1      fill bit for SHL / SRL
//   q    out WIDTH  stage output
module barrel_shifter_pipe_shift_stage
  import barrel_shifter_pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  input  logic [1:0]       op,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  // Composing power-of-two stages gives the full shift: fill and sign
  // bits repeat consistently, and rotates compose modulo WIDTH.
  always_comb begin
    q = d;
    if (en) begin
      case (shift_op_e'(op))
        OP_SHL:  q = {d[WIDTH-1-DIST:0], {DIST{fill}}};
        OP_SRL:  q = {{DIST{fill}}, d[WIDTH-1:DIST]};
        OP_SRA:  q = {{DIST{d[WIDTH-1]}}, d[WIDTH-1:DIST]};
        OP_ROTL: q = {d[WIDTH-1-DIST:0], d[WIDTH-1:WIDTH-DIST]};
        default: q = d;
      endcase
    end
  end

endmodule

// File: rtl/barrel_shifter_pipe.sv
// rtl/barrel_shifter_pipe.sv - pipelined barrel shifter (SHL/SRL with fill, SRA, ROTL) with valid/ready
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   in_data/in_amt      operand and shift amount (0..WIDTH-1)
//   in_op/in_fill       shift_op_e operation, fill bit for SHL/SRL
//   out_valid/out_ready output handshake
//   out_data            result; holds last value while out_valid=0
module barrel_shifter_pipe
  import barrel_shifter_pipe_pkg::*;
#(
  parameter  int WIDTH       = 32,
  parameter  int PIPE_STAGES = 2,
  localparam int SHW         = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_amt,
  input  logic [1:0]       in_op,
  input  logic             in_fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  localparam int P = PIPE_STAGES;

  logic             adv;
  logic [P-1:0]     rvalid;
  logic [P-1:0]     vin;
  logic [WIDTH-1:0] rdata    [P];
  logic [WIDTH-1:0] rank_out [P];

  // Operand/metadata presented to each rank's combinational stages.
  logic [WIDTH-1:0] rin_data [P];
  logic [SHW-1:0]   rin_amt  [P];
  logic [1:0]       rin_op   [P];
  logic             rin_fill [P];

  logic [WIDTH-1:0] sout [SHW];

  // All ranks move together; a stalled output freezes the whole pipe.
  assign adv       = !rvalid[P-1] || out_ready;
  assign in_ready  = adv;
  assign out_valid = rvalid[P-1];
  assign out_data  = rdata[P-1];

  assign rin_data[0] = in_data;
  assign rin_amt[0]  = in_amt;
  assign rin_op[0]   = in_op;
  assign rin_fill[0] = in_fill;

  generate
    if (P > 1) begin : g_vin
      assign vin = {rvalid[P-2:0], in_valid};
    end else begin : g_vin1
      assign vin = in_valid;
    end
  endgenerate

  // Log stages: each stage is fed either by its rank's input or by the
  // previous stage in the same rank.
  generate
    for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int RK = rank_of(k, SHW, P);
      logic [WIDTH-1:0] sin;
      if (k == rank_first(RK, SHW, P)) begin : g_head
        assign sin = rin_data[RK];
      end else begin : g_chain
        assign sin = sout[(k > 0) ? k - 1 : 0];
      end
      barrel_shifter_pipe_shift_stage #(
        .WIDTH (WIDTH),
        .DIST  (1 << k)
      ) u_stage (
        .d    (sin),
        .en   (rin_amt[RK][k]),
        .op   (rin_op[RK]),
        .fill (rin_fill[RK]),
        .q    (sout[k])
      );
    end

    for (genvar r = 0; r < P; r++) begin : g_rank_out
      assign rank_out[r] = sout[rank_first(r + 1, SHW, P) - 1];
    end
  endgenerate

  // Data registers load only with valid content so out_data keeps the
  // last result across bubbles.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid <= '0;
      for (int r = 0; r < P; r++) rdata[r] <= '0;
    end else if (adv) begin
      rvalid <= vin;
      for (int r = 0; r < P; r++) begin
        if (vin[r]) rdata[r] <= rank_out[r];
      end
    end
  end

  // Amount/op/fill ride along beside rdata[r-1] to feed rank r.
  generate
    if (P > 1) begin : g_meta
      logic [SHW-1:0] mamt  [1:P-1];
      logic [1:0]     mop   [1:P-1];
      logic           mfill [1:P-1];

      always_ff @(posedge clk) begin
        if (rst) begin
          for (int r = 1; r < P; r++) begin
            mamt[r]  <= '0;
            mop[r]   <= '0;
            mfill[r] <= 1'b0;
          end
        end else if (adv) begin
          for (int r = 1; r < P; r++) begin
            if (vin[r-1]) begin
              mamt[r]  <= rin_amt[r-1];
              mop[r]   <= rin_op[r-1];
              mfill[r] <= rin_fill[r-1];
            end
          end
        end
      end

      for (genvar r = 1; r < P; r++) begin : g_rin
        assign rin_data[r] = rdata[r-1];
        assign rin_amt[r]  = mamt[r];
        assign rin_op[r]   = mop[r];
        assign rin_fill[r] = mfill[r];
      end
    end
  endgenerate

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// tb/tb_barrel_shifter_pipe.sv - self-checking bench for barrel_shifter_pipe
module tb_barrel_shifter_pipe;
  import barrel_shifter_pipe_pkg::*;

  localparam int W   = 32;
  localparam int P   = 2;
  localparam int SHW = $clog2(W);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [W-1:0]   in_data = '0;
  logic [SHW-1:0] in_amt = '0;
  logic [1:0]     in_op = '0;
  logic           in_fill = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   out_data;

  always #5 clk = ~clk;

  barrel_shifter_pipe #(.WIDTH(W), .PIPE_STAGES(P)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_op     (in_op),
    .in_fill   (in_fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference result straight from the op definitions.
  function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a,
                                             input logic [1:0] op, input logic fill);
    logic [W-1:0] ones;
    logic [W-1:0] r;
    ones = '1;
    case (op)
      2'b00:   r = (d << a) | (fill ? ~(ones << a) : '0);
      2'b01:   r = (d >> a) | (fill ? ~(ones >> a) : '0);
      2'b10:   r = $signed(d) >>> a;
      default: r = (a == 0) ? d : ((d << a) | (d >> (W - a)));
    endcase
    return r;
  endfunction

  // Model: in-flight results with the number of advancing edges still
  // needed before they reach the output.
  typedef struct {
    logic [W-1:0] data;
    int           rem;
  } item_t;

  item_t        mq[$];
  logic [W-1:0] got[$];
  logic [W-1:0] last_out = '0;
  int           out_count = 0;
  bit           mon_on = 1'b0;

  always @(negedge clk) begin : monitor
    bit exp_valid;
    bit adv_m;
    exp_valid = (mq.size() > 0) && (mq[0].rem == 0);
    if (mon_on) begin
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, !exp_valid || out_ready);
      if (exp_valid) chk("out_data", out_data, mq[0].data);
      else           chk("out_data_hold", out_data, last_out);
    end
    if (exp_valid) last_out = mq[0].data;
    adv_m = !exp_valid || out_ready;
    if (exp_valid && out_ready) begin
      got.push_back(mq[0].data);
      void'(mq.pop_front());
      out_count++;
    end
    if (adv_m) begin
      foreach (mq[i]) if (mq[i].rem > 0) mq[i].rem--;
      if (in_valid)
        mq.push_back('{data: ref_shift(in_data, int'(in_amt), in_op, in_fill), rem: P - 1});
    end
    if (rst) begin
      mq.delete();
      last_out = '0;
    end
  end

  // Called away from a rising edge; returns 1 time unit after the accepting edge.
  task automatic send(input logic [W-1:0] d, input int a, input logic [1:0] op, input logic fill);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = SHW'(a);
    in_op    = op;
    in_fill  = fill;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready low for %0d cycles, required acceptance", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input string name, input logic [W-1:0] d, input int a,
                         input logic [1:0] op, input logic fill, input logic [W-1:0] expv);
    int lat;
    chk({name, "_model"}, ref_shift(d, a, op, fill), expv);
    out_ready = 1'b1;
    send(d, a, op, fill);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
    chk({name, "_lat"}, lat, P);
    chk({name, "_data"}, out_data, expv);
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] s_d   [5] = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_0000, 32'h1234_5678, 32'h0000_00FF};
  int           s_a   [5] = '{1, 31, 16, 8, 4};
  logic [1:0]   s_op  [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
  logic         s_f   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [W-1:0] s_exp [5] = '{32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFF, 32'h3456_7812, 32'hF000_000F};

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit saw_low;
    bit rnd_done;
    int c0;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 1);
    mon_on = 1'b1;
    @(posedge clk);
    #1;

    run_one("shl31",    32'h0000_0001, 31, OP_SHL, 1'b0, 32'h8000_0000);
    run_one("shl4f",    32'h0000_00F0, 4,  OP_SHL, 1'b1, 32'h0000_0F0F);
    run_one("srl8",     32'hF000_0000, 8,  OP_SRL, 1'b0, 32'h00F0_0000);
    run_one("sra_neg",  32'h8000_0000, 4,  OP_SRA, 1'b0, 32'hF800_0000);
    run_one("sra_pos",  32'h4000_0000, 4,  OP_SRA, 1'b1, 32'h0400_0000);
    run_one("rotl1",    32'h8000_0001, 1,  OP_ROTL, 1'b0, 32'h0000_0003);
    run_one("sra31",    32'h8000_0000, 31, OP_SRA, 1'b0, 32'hFFFF_FFFF);
    run_one("rotl31",   32'h0000_0001, 31, OP_ROTL, 1'b1, 32'h8000_0000);
    run_one("srl31f",   32'h0000_0000, 31, OP_SRL, 1'b1, 32'hFFFF_FFFE);
    run_one("a0_shl",   32'hDEAD_BEEF, 0,  OP_SHL, 1'b1, 32'hDEAD_BEEF);
    run_one("a0_srl",   32'hDEAD_BEEF, 0,  OP_SRL, 1'b1, 32'hDEAD_BEEF);
    run_one("a0_sra",   32'hDEAD_BEEF, 0,  OP_SRA, 1'b0, 32'hDEAD_BEEF);
    run_one("a0_rotl",  32'hDEAD_BEEF, 0,  OP_ROTL, 1'b0, 32'hDEAD_BEEF);

    // Back-to-back stream with the output stalled for cycles 3..6.
    got.delete();
    c0 = out_count;
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(s_d[i], s_a[i], s_op[i], s_f[i]);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (4) begin
          @(negedge clk);
          if (!in_ready) saw_low = 1'b1;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (P + 4) @(negedge clk);
    chk("stream_inready_low", saw_low, 1);
    chk("stream_count", out_count - c0, 5);
    chk("stream_drain", mq.size(), 0);
    for (int i = 0; i < 5; i++) begin
      if (i < got.size()) chk($sformatf("stream_res%0d", i), got[i], s_exp[i]);
      else chk($sformatf("stream_res%0d_missing", i), got.size(), 5);
    end
    @(posedge clk);
    #1;

    // Fill the pipe, then reset for one cycle.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hFFFF_FFFF;
    in_amt    = '0;
    in_op     = OP_SHL;
    in_fill   = 1'b0;
    repeat (P + 1) @(posedge clk);
    #1;
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    @(posedge clk);
    #1;
    run_one("after_rst", 32'h0000_00A5, 3, OP_ROTL, 1'b0, 32'h0000_0528);

    // Random ops with random gaps and random output back-pressure.
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          send($urandom, $urandom_range(0, W - 1), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    repeat (P + 6) @(negedge clk);
    chk("final_drain", mq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
